// File: rtl/escaner_teclado4x4.sv
// -----------------------------------------------------------------------------
// escaner_teclado4x4
// Multiplexed 4x4 matrix-keypad scanner. Drives one column low at a time,
// samples the (synchronized) row lines at the end of each column dwell,
// builds a per-scan key candidate, debounces it over whole scans and reports
// a single pressed key as a 4-bit hex code.
//
// Parameters
//   SCAN_TICKS     : clock cycles each column stays driven (>= 4)
//   DEBOUNCE_SCANS : consecutive identical scans needed to accept a change (>= 1)
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   row_n     : keypad rows, active-low, asynchronous to clk
//   col_n     : column drive, active-low one-hot
//   key_code  : hex code of the last accepted key
//   key_valid : one-cycle pulse when a new key is accepted
//   key_held  : high while a debounced single key is pressed
// -----------------------------------------------------------------------------
module escaner_teclado4x4 #(
    parameter int SCAN_TICKS     = 10000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_TICKS - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    // Candidate: vld=0 means NONE; code is kept 0 for NONE so that plain
    // struct equality compares candidates correctly.
    typedef struct packed {
        logic       vld;
        logic [3:0] code;
    } cand_t;

    localparam cand_t CAND_NONE = '{vld: 1'b0, code: 4'h0};

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    // State
    logic [3:0]    row_s1_q, row_s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    col_q, col_d;
    logic [1:0]    hits_q, hits_d;       // keys seen this scan, 2 = "two or more"
    logic [3:0]    scode_q, scode_d;     // code of the first key seen this scan
    cand_t         prev_q, prev_d;
    cand_t         acc_q, acc_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    // Per-column decode of the synchronized rows
    logic [1:0] col_hits;
    logic [1:0] col_row;

    always_comb begin
        col_hits = 2'd0;
        col_row  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s2_q[r]) begin
                if (col_hits == 2'd0) col_row = 2'(r);
                if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
            end
        end
    end

    // Scan accumulation, candidate and debounce
    logic       sample;
    logic       end_scan;
    logic [1:0] base_hits;
    logic [3:0] base_code;
    logic [2:0] tot_hits;
    cand_t      cand;

    always_comb begin
        sample   = (cnt_q == CNT_LAST);
        end_scan = sample && (col_idx_q == 2'd3);

        // Column 0 opens a fresh scan; anything left from the previous one is dropped.
        base_hits = (col_idx_q == 2'd0) ? 2'd0 : hits_q;
        base_code = (col_idx_q == 2'd0) ? 4'h0 : scode_q;
        tot_hits  = {1'b0, base_hits} + {1'b0, col_hits};

        cnt_d       = cnt_q + CW'(1);
        col_idx_d   = col_idx_q;
        col_d       = col_q;
        hits_d      = hits_q;
        scode_d     = scode_q;
        prev_d      = prev_q;
        acc_d       = acc_q;
        stable_d    = stable_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        cand        = CAND_NONE;

        if (sample) begin
            cnt_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            col_d     = {col_q[2:0], col_q[3]};
            hits_d    = (tot_hits > 3'd2) ? 2'd2 : tot_hits[1:0];
            scode_d   = (base_hits == 2'd0 && col_hits != 2'd0) ?
                        key_map(col_row, col_idx_q) : base_code;
        end

        if (end_scan) begin
            if (hits_d == 2'd1) cand = '{vld: 1'b1, code: scode_d};

            if (cand == prev_q)
                stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + SW'(1);
            else
                stable_d = SW'(1);
            prev_d = cand;

            if (stable_d == STABLE_MAX && cand != acc_q) begin
                acc_d = cand;
                if (cand.vld) begin
                    key_code_d  = cand.code;
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                end else begin
                    // Release: code is kept so downstream still shows the last key.
                    key_held_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            cnt_q       <= '0;
            col_idx_q   <= 2'd0;
            col_q       <= 4'b1110;
            hits_q      <= 2'd0;
            scode_q     <= 4'h0;
            prev_q      <= CAND_NONE;
            acc_q       <= CAND_NONE;
            stable_q    <= STABLE_MAX;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_s1_q    <= row_n;
            row_s2_q    <= row_s1_q;
            cnt_q       <= cnt_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            hits_q      <= hits_d;
            scode_q     <= scode_d;
            prev_q      <= prev_d;
            acc_q       <= acc_d;
            stable_q    <= stable_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_n     = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_escaner_teclado4x4.sv
// -----------------------------------------------------------------------------
// tb_escaner_teclado4x4
// Directed bench for the keypad scanner with SCAN_TICKS=4, DEBOUNCE_SCANS=2
// (16-cycle scan). A keypad model pulls row r low while column c is driven
// low and key (r,c) is set in 'pressed' (bit r*4+c).
// -----------------------------------------------------------------------------
module tb_escaner_teclado4x4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;

    int n_assert = 0;
    int n_fail   = 0;
    int n_pulse  = 0;
    int n_dbl    = 0;
    logic kv_prev = 1'b0;

    escaner_teclado4x4 #(
        .SCAN_TICKS    (4),
        .DEBOUNCE_SCANS(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    // key_valid pulse counter and back-to-back detector
    always @(negedge clk) begin
        if (key_valid) n_pulse++;
        if (key_valid && kv_prev) n_dbl++;
        kv_prev = key_valid;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scan();
        repeat (16) step();
    endtask

    initial begin
        logic [3:0] exp_col;
        pressed = 16'h0;
        rst_n   = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst col_n",     {4'h0, col_n},    8'h0E);
        chk("rst key_code",  {4'h0, key_code}, 8'h00);
        chk("rst key_valid", {7'h0, key_valid}, 8'h00);
        chk("rst key_held",  {7'h0, key_held},  8'h00);
        #19 rst_n = 1'b1;   // released between edges

        // Idle: column rotation, 4 cycles per column
        for (int i = 1; i <= 32; i++) begin
            step();
            exp_col = 4'b0001 << ((i / 4) % 4);
            exp_col = ~exp_col;
            chk($sformatf("idle col_n step %0d", i), {4'h0, col_n}, {4'h0, exp_col});
        end
        chk("idle key_held", {7'h0, key_held}, 8'h00);
        chk("idle pulses", 8'(n_pulse), 8'd0);

        // Press r1c2 (code 6) at a scan boundary
        pressed = 16'h0040;
        scan();
        chk("press scan1 held",  {7'h0, key_held},  8'h00);
        chk("press scan1 valid", {7'h0, key_valid}, 8'h00);
        repeat (15) step();
        chk("press pre-edge valid", {7'h0, key_valid}, 8'h00);
        step();
        chk("press scan2 valid", {7'h0, key_valid}, 8'h01);
        chk("press scan2 code",  {4'h0, key_code},  8'h06);
        chk("press scan2 held",  {7'h0, key_held},  8'h01);
        step();
        chk("press pulse width", {7'h0, key_valid}, 8'h00);
        repeat (15) step();
        chk("press scan3 valid", {7'h0, key_valid}, 8'h00);
        chk("press scan3 held",  {7'h0, key_held},  8'h01);
        scan();
        pressed = 16'h0;
        scan();
        chk("release scan1 held", {7'h0, key_held}, 8'h01);
        scan();
        chk("release scan2 held", {7'h0, key_held}, 8'h00);
        chk("release code kept",  {4'h0, key_code}, 8'h06);
        chk("release valid",      {7'h0, key_valid}, 8'h00);
        chk("press pulses", 8'(n_pulse), 8'd1);

        // Bounce: key 5 on alternate scans
        for (int k = 0; k < 8; k++) begin
            pressed = (k % 2 == 0) ? 16'h0020 : 16'h0000;
            scan();
            chk($sformatf("bounce scan %0d held", k),  {7'h0, key_held},  8'h00);
            chk($sformatf("bounce scan %0d valid", k), {7'h0, key_valid}, 8'h00);
        end
        chk("bounce pulses", 8'(n_pulse), 8'd1);

        // Multi-key: accept 5, then add r0c0
        pressed = 16'h0020;
        scan();
        chk("multi scan1 held", {7'h0, key_held}, 8'h00);
        scan();
        chk("multi accept valid", {7'h0, key_valid}, 8'h01);
        chk("multi accept code",  {4'h0, key_code},  8'h05);
        chk("multi accept held",  {7'h0, key_held},  8'h01);
        pressed = 16'h0021;
        scan();
        chk("multi two-key scan1 held",  {7'h0, key_held},  8'h01);
        chk("multi two-key scan1 valid", {7'h0, key_valid}, 8'h00);
        scan();
        chk("multi two-key scan2 held",  {7'h0, key_held},  8'h00);
        chk("multi two-key scan2 valid", {7'h0, key_valid}, 8'h00);
        chk("multi two-key code",        {4'h0, key_code},  8'h05);
        chk("multi pulses", 8'(n_pulse), 8'd2);
        pressed = 16'h0;

        // Rollover: 0 (r3c1) then directly D (r3c3)
        pressed = 16'h2000;
        scan();
        chk("roll scan1 held", {7'h0, key_held}, 8'h00);
        scan();
        chk("roll 0 valid", {7'h0, key_valid}, 8'h01);
        chk("roll 0 code",  {4'h0, key_code},  8'h00);
        chk("roll 0 held",  {7'h0, key_held},  8'h01);
        pressed = 16'h8000;
        scan();
        chk("roll switch held",  {7'h0, key_held},  8'h01);
        chk("roll switch valid", {7'h0, key_valid}, 8'h00);
        chk("roll switch code",  {4'h0, key_code},  8'h00);
        scan();
        chk("roll D valid", {7'h0, key_valid}, 8'h01);
        chk("roll D code",  {4'h0, key_code},  8'h0D);
        chk("roll D held",  {7'h0, key_held},  8'h01);

        // Async reset mid-dwell of column 2 with D held
        repeat (9) step();
        chk("pre-reset col_n", {4'h0, col_n}, 8'h0B);
        #2 rst_n = 1'b0;
        #1;
        chk("areset col_n",     {4'h0, col_n},    8'h0E);
        chk("areset key_code",  {4'h0, key_code}, 8'h00);
        chk("areset key_valid", {7'h0, key_valid}, 8'h00);
        chk("areset key_held",  {7'h0, key_held},  8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        scan();
        chk("post-reset scan1 held",  {7'h0, key_held}, 8'h00);
        chk("post-reset scan1 col_n", {4'h0, col_n},    8'h0E);
        scan();
        chk("post-reset accept valid", {7'h0, key_valid}, 8'h01);
        chk("post-reset accept code",  {4'h0, key_code},  8'h0D);
        chk("post-reset accept held",  {7'h0, key_held},  8'h01);
        pressed = 16'h0;
        repeat (2) step();
        chk("total pulses", 8'(n_pulse), 8'd5);
        chk("back-to-back valid", 8'(n_dbl), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
